// File: rtl/extender_kmer_assembler_pkg.sv
// Shared constants and types for the extender kmer assembler.
// Kmers are packed first base in the MSBs.
package extender_kmer_assembler_pkg;

  localparam int unsigned BASE_LEN                = 2;
  localparam int unsigned ONE_HOT_LEN             = 4;
  localparam int unsigned EXTENDER_OUT_PART_COUNT = 2;
  localparam int unsigned KMER_LEN                = 4;

  localparam int unsigned PARTS_PER_KMER  = KMER_LEN / EXTENDER_OUT_PART_COUNT;
  localparam int unsigned KMER_NBASES_LEN = $clog2(KMER_LEN + 1);
  localparam int unsigned PART_CNT_LEN    = $clog2(PARTS_PER_KMER + 1);
  localparam int unsigned KMER_BITS       = KMER_LEN * BASE_LEN;
  localparam int unsigned PART_BITS       = EXTENDER_OUT_PART_COUNT * BASE_LEN;
  localparam int unsigned PART_IN_BITS    = EXTENDER_OUT_PART_COUNT * ONE_HOT_LEN;

  typedef enum logic {FILL, FULL} assembler_state_e;

  typedef struct packed {
    logic [KMER_BITS-1:0]       kmer;
    logic [KMER_NBASES_LEN-1:0] nbases;
    logic                       last;
  } kmer_pack;

endpackage

// File: rtl/extender_kmer_assembler_decoder.sv
// One-hot base to binary code decoder for one lane.
// Patterns that are not exactly one-hot decode to A and raise err.
module onehot_base_decoder
  import extender_kmer_assembler_pkg::*;
(
  input  logic [ONE_HOT_LEN-1:0] onehot,
  output logic [BASE_LEN-1:0]    base,
  output logic                   err
);

  always_comb begin
    base = '0;
    err  = 1'b0;
    case (onehot)
      4'b0001: base = 2'b00;
      4'b0010: base = 2'b01;
      4'b0100: base = 2'b10;
      4'b1000: base = 2'b11;
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/extender_kmer_assembler.sv
// Packs decoded one-hot extender parts into kmers with a valid/ready output.
// A part_last flushes a partial kmer; malformed bases set a sticky error flag.
module extender_kmer_assembler
  import extender_kmer_assembler_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PART_IN_BITS-1:0]    part_in,
  input  logic                       part_valid,
  input  logic                       part_last,
  output logic                       part_ready,
  output logic [KMER_BITS-1:0]       kmer_out,
  output logic [KMER_NBASES_LEN-1:0] kmer_nbases,
  output logic                       kmer_last,
  output logic                       kmer_valid,
  input  logic                       kmer_ready,
  output logic                       onehot_err
);

  assembler_state_e           state;
  logic [PART_CNT_LEN-1:0]    part_cnt;
  logic [KMER_BITS-1:0]       asm_reg;
  kmer_pack                   out_reg;

  logic [PART_BITS-1:0]               part_bits;
  logic [EXTENDER_OUT_PART_COUNT-1:0] lane_err;
  logic [KMER_BITS-1:0]               asm_next;
  logic [KMER_NBASES_LEN-1:0]         nb_next;
  logic                               in_fire, out_fire, part_done;

  for (genvar l = 0; l < EXTENDER_OUT_PART_COUNT; l++) begin : g_lane
    logic [BASE_LEN-1:0] base;
    onehot_base_decoder u_dec (
      .onehot (part_in[l*ONE_HOT_LEN +: ONE_HOT_LEN]),
      .base   (base),
      .err    (lane_err[l])
    );
    // Lane 0 is the earliest base, so it takes the most significant slot.
    assign part_bits[PART_BITS-1-l*BASE_LEN -: BASE_LEN] = base;
  end

  assign kmer_valid  = (state == FULL);
  assign kmer_out    = out_reg.kmer;
  assign kmer_nbases = out_reg.nbases;
  assign kmer_last   = out_reg.last;
  assign part_ready  = !rst && (!kmer_valid || kmer_ready);
  assign in_fire     = part_valid && part_ready;
  assign out_fire    = kmer_valid && kmer_ready;
  assign part_done   = part_last || (part_cnt == PART_CNT_LEN'(PARTS_PER_KMER - 1));

  always_comb begin
    asm_next = asm_reg;
    for (int s = 0; s < int'(PARTS_PER_KMER); s++) begin
      if (part_cnt == PART_CNT_LEN'(s)) begin
        asm_next[KMER_BITS-1-s*PART_BITS -: PART_BITS] = part_bits;
      end
    end
    nb_next = KMER_NBASES_LEN'((int'(part_cnt) + 1) * int'(EXTENDER_OUT_PART_COUNT));
  end

  // asm_reg and part_cnt are cleared as a kmer is handed over, so a part accepted
  // in the same cycle as an output fire always starts a fresh kmer at slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      part_cnt   <= '0;
      asm_reg    <= '0;
      out_reg    <= '0;
      onehot_err <= 1'b0;
    end else begin
      if (in_fire) begin
        if (|lane_err) onehot_err <= 1'b1;
        if (part_done) begin
          out_reg  <= '{kmer: asm_next, nbases: nb_next, last: part_last};
          state    <= FULL;
          asm_reg  <= '0;
          part_cnt <= '0;
        end else begin
          asm_reg  <= asm_next;
          part_cnt <= part_cnt + PART_CNT_LEN'(1);
        end
      end
      if (out_fire && !(in_fire && part_done)) begin
        state <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_extender_kmer_assembler.sv
// Scoreboard bench for extender_kmer_assembler: a base-list reference model
// predicts each kmer; a monitor pops and compares on every output handshake.
module tb_extender_kmer_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] part_in = '0;
  logic       part_valid = 1'b0, part_last = 1'b0, kmer_ready = 1'b0;
  logic [7:0] kmer_out;
  logic [2:0] kmer_nbases;
  logic       kmer_last, kmer_valid, part_ready, onehot_err;

  extender_kmer_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .part_in     (part_in),
    .part_valid  (part_valid),
    .part_last   (part_last),
    .part_ready  (part_ready),
    .kmer_out    (kmer_out),
    .kmer_nbases (kmer_nbases),
    .kmer_last   (kmer_last),
    .kmer_valid  (kmer_valid),
    .kmer_ready  (kmer_ready),
    .onehot_err  (onehot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] k;
    logic [2:0] nb;
    logic       last;
  } exp_t;

  int         total = 0, bad = 0, cycles = 0;
  exp_t       exp_q[$];
  logic [1:0] cur_bases[$];
  logic       err_exp = 1'b0;
  bit         rand_rdy = 1'b0;
  logic       mon_stall = 1'b0;
  logic [11:0] mon_prev = '0;

  always @(posedge clk) cycles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Returns {err, code}; a legal one-hot value is a power of two whose log2 is the code.
  function automatic logic [2:0] dec(input logic [3:0] oh);
    if ($countones(oh) == 1) return {1'b0, 2'($clog2(oh))};
    return 3'b100;
  endfunction

  function automatic logic [7:0] rnd_part();
    logic [3:0] a, b;
    a = 4'b0001 << $urandom_range(0, 3);
    b = 4'b0001 << $urandom_range(0, 3);
    return {b, a};
  endfunction

  task automatic model_accept(input logic [7:0] p, input logic l);
    exp_t e;
    logic [2:0] d;
    for (int i = 0; i < 2; i++) begin
      d = dec(p[i*4 +: 4]);
      err_exp = err_exp | d[2];
      cur_bases.push_back(d[1:0]);
    end
    if (cur_bases.size() == 4 || l) begin
      e.k = '0;
      for (int i = 0; i < cur_bases.size(); i++) e.k = e.k | (8'(cur_bases[i]) << (6 - 2 * i));
      e.nb   = 3'(cur_bases.size());
      e.last = l;
      exp_q.push_back(e);
      cur_bases.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] p, input logic l);
    part_in    = p;
    part_last  = l;
    part_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (part_ready) begin
        @(posedge clk);
        model_accept(p, l);
        #1;
        if (rand_rdy) kmer_ready = 1'($urandom_range(0, 1));
        return;
      end
      @(posedge clk);
      #1;
      if (rand_rdy) kmer_ready = 1'($urandom_range(0, 1));
    end
    timeout("send");
  endtask

  task automatic idle(input int n);
    part_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) kmer_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    part_valid = 1'b0;
    kmer_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !kmer_valid) return;
    end
    timeout("drain");
  endtask

  // Monitor: compares each accepted kmer and checks outputs hold while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall)
          check("hold_stable", 32'({kmer_valid, kmer_out, kmer_nbases, kmer_last}),
                32'({1'b1, mon_prev}));
        if (kmer_valid && kmer_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_kmer: got %0h want none", kmer_out);
          end else begin
            e = exp_q.pop_front();
            check("kmer", 32'({kmer_out, kmer_nbases, kmer_last}), 32'({e.k, e.nb, e.last}));
          end
        end
        mon_stall = kmer_valid && !kmer_ready;
        mon_prev  = {kmer_out, kmer_nbases, kmer_last};
      end
    end
  end

  initial begin
    int c0;
    #12;
    check("reset_outputs", 32'({kmer_valid, onehot_err, kmer_out, kmer_nbases, kmer_last}), 32'h0);
    check("reset_part_ready", 32'(part_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    kmer_ready = 1'b1;

    // Two parts, no stalls: ACGT with one cycle latency.
    send(8'h21, 1'b0);
    send(8'h84, 1'b0);
    check("two_part_kmer", 32'({kmer_valid, kmer_out, kmer_nbases, kmer_last}),
          32'({1'b1, 8'h1B, 3'd4, 1'b0}));
    drain();

    // Backpressure: completed kmer held, input blocked, released same cycle.
    kmer_ready = 1'b0;
    send(8'h21, 1'b0);
    send(8'h84, 1'b0);
    part_in = 8'h21;
    part_last = 1'b1;
    part_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_part_ready", 32'(part_ready), 32'h0);
      check("bp_kmer_hold", 32'({kmer_valid, kmer_out}), 32'({1'b1, 8'h1B}));
      @(posedge clk);
      #1;
    end
    kmer_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(part_ready), 32'h1);
    @(posedge clk);
    model_accept(8'h21, 1'b1);
    #1;
    check("bp_next_kmer", 32'({kmer_valid, kmer_out, kmer_nbases, kmer_last}),
          32'({1'b1, 8'h10, 3'd2, 1'b1}));
    drain();

    // Partial flush on a single last part.
    send(8'h48, 1'b1);
    check("partial_flush", 32'({kmer_valid, kmer_out, kmer_nbases, kmer_last}),
          32'({1'b1, 8'hE0, 3'd2, 1'b1}));
    drain();

    // Malformed base sets the sticky error.
    check("err_clear", 32'(onehot_err), 32'h0);
    send(8'h31, 1'b0);
    check("err_set", 32'(onehot_err), 32'h1);
    send(8'h21, 1'b1);
    drain();

    // Back-to-back stream of 8 parts, one accepted per cycle.
    c0 = cycles;
    for (int i = 0; i < 8; i++) send(rnd_part(), i == 7);
    check("b2b_cycles", 32'(cycles - c0), 32'd8);
    drain();
    check("err_sticky", 32'(onehot_err), 32'h1);

    // Random stream with random backpressure and gaps.
    rand_rdy = 1'b1;
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(($urandom_range(0, 15) == 0) ? 8'($urandom) : rnd_part(), $urandom_range(0, 5) == 0);
    end
    rand_rdy = 1'b0;
    drain();
    check("err_model", 32'(onehot_err), 32'(err_exp));

    // Async reset after one part of a kmer discards it.
    send(8'h21, 1'b0);
    part_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_out",
          32'({kmer_valid, part_ready, onehot_err, kmer_out, kmer_nbases, kmer_last}), 32'h0);
    cur_bases.delete();
    exp_q.delete();
    err_exp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h84, 1'b0);
    send(8'h21, 1'b0);
    check("post_reset_kmer", 32'({kmer_valid, kmer_out, kmer_nbases, kmer_last}),
          32'({1'b1, 8'hB1, 3'd4, 1'b0}));
    drain();
    check("post_reset_err", 32'(onehot_err), 32'(err_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
